// File: rtl/ula_dispatcher.sv
// Round-robin issue stage for a shared ULA: grants one core at a time, holds its
// operands on the ULA for ALU_LATENCY cycles, then returns result/flags tagged with the core id.
module ula_dispatcher #(
  parameter int unsigned N_CORES     = 2,
  parameter int unsigned ALU_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CORES-1:0]         req_valid,
  input  logic [4*N_CORES-1:0]       req_op,
  input  logic [8*N_CORES-1:0]       req_a,
  input  logic [8*N_CORES-1:0]       req_b,
  output logic [N_CORES-1:0]         req_ack,
  output logic [3:0]                 ula_operation,
  output logic [7:0]                 ula_operand1,
  output logic [7:0]                 ula_operand2,
  input  logic [7:0]                 ula_result,
  input  logic [3:0]                 ula_flags,
  input  logic                       ula_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_CORES)-1:0] rsp_core,
  output logic [7:0]                 rsp_result,
  output logic [3:0]                 rsp_flags,
  output logic                       busy
);

  localparam int unsigned IdW  = $clog2(N_CORES);
  localparam int unsigned CntW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_CORES-1:0]  ack_q, ack_d;
  logic [3:0]          op_q, op_d;
  logic [7:0]          a_q, a_d;
  logic [7:0]          b_q, b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]      rsp_core_q, rsp_core_d;
  logic [7:0]          rsp_result_q, rsp_result_d;
  logic [3:0]          rsp_flags_q, rsp_flags_d;
  logic                busy_q, busy_d;

  logic                grant_found;
  logic [IdW-1:0]      grant_id;
  logic [IdW-1:0]      cand;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= int'(N_CORES); k++) begin
      cand = IdW'((int'(ptr_q) + k) % int'(N_CORES));
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = 1'b0;
    rsp_core_d   = rsp_core_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          ack_d[grant_id] = 1'b1;
          op_d            = req_op[int'(grant_id)*4 +: 4];
          a_d             = req_a[int'(grant_id)*8 +: 8];
          b_d             = req_b[int'(grant_id)*8 +: 8];
          ptr_d           = grant_id;
          cnt_d           = '0;
          state_d         = StExec;
        end
      end
      StExec: begin
        if (cnt_q == CntMax && ula_ready) begin
          rsp_core_d   = ptr_q;
          rsp_result_d = ula_result;
          rsp_flags_d  = ula_flags;
          // ULA inputs return to zero once the operation has been captured.
          op_d         = '0;
          a_d          = '0;
          b_d          = '0;
          state_d      = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= IdW'(N_CORES - 1);
      cnt_q        <= '0;
      ack_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_core_q   <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_core_q   <= rsp_core_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ack       = ack_q;
  assign ula_operation = op_q;
  assign ula_operand1  = a_q;
  assign ula_operand2  = b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_core      = rsp_core_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign busy          = busy_q;

endmodule
